// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared mini-MIPS definitions for the register file
//
// Purpose : HI/LO operation encodings and the hardwired-zero register index,
//           imported by the register file, its HI/LO unit and its interface.
// Ports   : none (package).
package mips_pkg;

   typedef enum logic [1:0] {
      HILO_NONE = 2'd0,
      HILO_LOAD = 2'd1,
      HILO_MADD = 2'd2,
      HILO_MSUB = 2'd3
   } hilo_op_e;

   // Register index that always reads zero and ignores writes/reservations.
   localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - decode/writeback bus of the multi-port register file
//
// Purpose : bundles the GPR write port, HI/LO port, reservation port and the
//           packed read ports.
// Ports   : master (datapath) drives we/wr_addr/wr_data, hilo_op/hilo_wdata,
//           rsv_en/rsv_addr, rd_addr and receives rd_data/rd_busy/hi_out/lo_out;
//           slave (register file) is the mirror image.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                       we;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic [1:0]                 hilo_op;
   logic [2*DATA_W-1:0]        hilo_wdata;
   logic                       rsv_en;
   logic [ADDR_W-1:0]          rsv_addr;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          rd_busy;
   logic [DATA_W-1:0]          hi_out;
   logic [DATA_W-1:0]          lo_out;

   modport master (
      output we, wr_addr, wr_data, hilo_op, hilo_wdata, rsv_en, rsv_addr, rd_addr,
      input  rd_data, rd_busy, hi_out, lo_out
   );

   modport slave (
      input  we, wr_addr, wr_data, hilo_op, hilo_wdata, rsv_en, rsv_addr, rd_addr,
      output rd_data, rd_busy, hi_out, lo_out
   );
endinterface

// File: rtl/regfile_hilo.sv
// rtl/regfile_hilo.sv - HI/LO register pair with load/accumulate/subtract
//
// Purpose : holds {hi,lo} as one 2*DATA_W word; load, add or subtract the
//           operand each edge, wrapping modulo 2^(2*DATA_W).
// Ports   : clk, rst (sync, active high), op (hilo_op_e), wdata ({hi,lo}
//           operand), hi/lo (current register contents, straight from flops).
module regfile_hilo
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  hilo_op_e            op,
   input  logic [2*DATA_W-1:0] wdata,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo
);

   logic [2*DATA_W-1:0] hilo_d, hilo_q;

   // Carry/borrow out of the top bit is dropped: accumulation simply wraps.
   always_comb begin
      hilo_d = hilo_q;
      case (op)
         HILO_LOAD: hilo_d = wdata;
         HILO_MADD: hilo_d = hilo_q + wdata;
         HILO_MSUB: hilo_d = hilo_q - wdata;
         default:   hilo_d = hilo_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hilo_q <= '0;
      end else begin
         hilo_q <= hilo_d;
      end
   end

   assign hi = hilo_q[2*DATA_W-1:DATA_W];
   assign lo = hilo_q[DATA_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port GPR file with pending-write scoreboard
//
// Purpose : 2**ADDR_W x DATA_W register file, r0 hardwired to zero, one write
//           port, NUM_RD registered read ports, per-register busy bits set by
//           reservations and cleared by writes, plus an independent HI/LO unit.
// Ports   : clk, rst (sync, active high), bus (regfile_mp_if.slave).
// Config  : REGFILE_BYPASS_EN defined -> a read sampled on the same edge as a
//           write/reservation returns the post-edge data and busy bit;
//           undefined -> it returns the pre-edge contents.
module regfile_mp
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
) (
   input  logic        clk,
   input  logic        rst,
   regfile_mp_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] gpr_d [DEPTH];
   logic [DATA_W-1:0] gpr_q [DEPTH];
   logic [DEPTH-1:0]  busy_d, busy_q;
   logic              wr_hit, rsv_hit;

   assign wr_hit  = bus.we     && (bus.wr_addr  != ADDR_W'(REG_ZERO));
   assign rsv_hit = bus.rsv_en && (bus.rsv_addr != ADDR_W'(REG_ZERO));

   // Entry 0 is never written and never reserved, so it stays zero/idle after
   // reset and the read ports need no special case for it.
   // Reservation is applied after the write so a same-edge pair leaves the
   // register busy: the new producer owns it.
   always_comb begin
      gpr_d  = gpr_q;
      busy_d = busy_q;
      if (wr_hit) begin
         gpr_d[bus.wr_addr]  = bus.wr_data;
         busy_d[bus.wr_addr] = 1'b0;
      end
      if (rsv_hit) begin
         busy_d[bus.rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            gpr_q[i] <= '0;
         end
         busy_q <= '0;
      end else begin
         gpr_q  <= gpr_d;
         busy_q <= busy_d;
      end
   end

   generate
      for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data_d, data_q;
         logic              busy_rd_d, busy_rd_q;

         assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

         // Bypass reads the next-state arrays so same-edge writes and
         // reservations are already visible; otherwise read the old state.
         always_comb begin
`ifdef REGFILE_BYPASS_EN
            data_d    = gpr_d[addr];
            busy_rd_d = busy_d[addr];
`else
            data_d    = gpr_q[addr];
            busy_rd_d = busy_q[addr];
`endif
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               data_q    <= '0;
               busy_rd_q <= 1'b0;
            end else begin
               data_q    <= data_d;
               busy_rd_q <= busy_rd_d;
            end
         end

         assign bus.rd_data[i*DATA_W +: DATA_W] = data_q;
         assign bus.rd_busy[i]                  = busy_rd_q;
      end
   endgenerate

   regfile_hilo #(
      .DATA_W (DATA_W)
   ) u_hilo (
      .clk   (clk),
      .rst   (rst),
      .op    (hilo_op_e'(bus.hilo_op)),
      .wdata (bus.hilo_wdata),
      .hi    (bus.hi_out),
      .lo    (bus.lo_out)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp
module tb_regfile_mp;
   import mips_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int DEPTH = 2 ** AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    busy;
      logic [DW-1:0]    hi;
      logic [DW-1:0]    lo;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0]   m_gpr [DEPTH];
   logic            m_busy[DEPTH];
   logic [2*DW-1:0] m_hilo;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_read(inout exp_t e);
      for (int p = 0; p < NR; p++) begin
         int a;
         a = int'(bus.rd_addr[p*AW +: AW]);
         e.data[p*DW +: DW] = (a == 0) ? '0 : m_gpr[a];
         e.busy[p]          = (a == 0) ? 1'b0 : m_busy[a];
      end
   endfunction

   // Apply the driven inputs to the reference model, queue the expected
   // post-edge outputs, then advance one clock.
   task automatic step();
      exp_t e;
      e = '0;
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            m_gpr[r]  = '0;
            m_busy[r] = 1'b0;
         end
         m_hilo = '0;
      end else begin
`ifndef REGFILE_BYPASS_EN
         model_read(e);
`endif
         if (bus.we && bus.wr_addr != 0) begin
            m_gpr[bus.wr_addr]  = bus.wr_data;
            m_busy[bus.wr_addr] = 1'b0;
         end
         if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
         case (bus.hilo_op)
            2'd1: m_hilo = bus.hilo_wdata;
            2'd2: m_hilo = m_hilo + bus.hilo_wdata;
            2'd3: m_hilo = m_hilo - bus.hilo_wdata;
            default: ;
         endcase
`ifdef REGFILE_BYPASS_EN
         model_read(e);
`endif
         e.hi = m_hilo[2*DW-1:DW];
         e.lo = m_hilo[DW-1:0];
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rst             = 1'b0;
      bus.we          = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.hilo_op     = 2'd0;
      bus.hilo_wdata  = '0;
      bus.rsv_en      = 1'b0;
      bus.rsv_addr    = '0;
      bus.rd_addr     = {a1, a0};
   endtask

   // Monitor: every edge produces outputs; compare them against the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int p = 0; p < NR; p++) begin
               chk($sformatf("rd_data%0d", p), bus.rd_data[p*DW +: DW], e.data[p*DW +: DW]);
               chk($sformatf("rd_busy%0d", p), DW'(bus.rd_busy[p]), DW'(e.busy[p]));
            end
            chk("hi_out", bus.hi_out, e.hi);
            chk("lo_out", bus.lo_out, e.lo);
         end
      end
   end

   initial begin
      logic [DW-1:0] same_edge_exp;
      // reset
      idle(5'd1, 5'd31);
      rst = 1'b1;
      step();
      step();
      idle(5'd1, 5'd31);
      step();
      chk("reset_r1", bus.rd_data[DW-1:0], 32'h0);
      chk("reset_r31", bus.rd_data[2*DW-1:DW], 32'h0);
      chk("reset_busy", DW'(bus.rd_busy), 32'h0);
      chk("reset_hi", bus.hi_out, 32'h0);
      chk("reset_lo", bus.lo_out, 32'h0);

      // write r5, read it back one cycle later
      idle(5'd0, 5'd0);
      bus.we = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
      step();
      idle(5'd5, 5'd0);
      step();
      chk("r5_read", bus.rd_data[DW-1:0], 32'hDEADBEEF);

      // write to r0 is ignored
      idle(5'd0, 5'd0);
      bus.we = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
      step();
      idle(5'd0, 5'd0);
      step();
      chk("r0_read", bus.rd_data[2*DW-1:DW], 32'h0);

      // same-edge write/read of r7
      idle(5'd0, 5'd0);
      bus.we = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h11;
      step();
      idle(5'd7, 5'd7);
      bus.we = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hA5;
      step();
`ifdef REGFILE_BYPASS_EN
      same_edge_exp = 32'hA5;
`else
      same_edge_exp = 32'h11;
`endif
      chk("r7_same_edge", bus.rd_data[DW-1:0], same_edge_exp);

      // HI/LO load, madd with carry across, msub wrapping
      idle(5'd0, 5'd0);
      bus.hilo_op = 2'd1; bus.hilo_wdata = {32'h1, 32'hFFFFFFFF};
      step();
      idle(5'd0, 5'd0);
      bus.hilo_op = 2'd2; bus.hilo_wdata = {32'h0, 32'h1};
      step();
      chk("madd_hi", bus.hi_out, 32'h2);
      chk("madd_lo", bus.lo_out, 32'h0);
      idle(5'd0, 5'd0);
      bus.hilo_op = 2'd3; bus.hilo_wdata = {32'h3, 32'h0};
      step();
      chk("msub_hi", bus.hi_out, 32'hFFFFFFFF);
      chk("msub_lo", bus.lo_out, 32'h0);

      // scoreboard reserve / write interplay on r9
      idle(5'd0, 5'd0);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
      step();
      idle(5'd9, 5'd0);
      step();
      chk("r9_busy_rsv", DW'(bus.rd_busy[0]), 32'h1);
      idle(5'd0, 5'd0);
      bus.we = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'd42;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
      step();
      idle(5'd9, 5'd0);
      step();
      chk("r9_busy_wr_rsv", DW'(bus.rd_busy[0]), 32'h1);
      chk("r9_data_wr_rsv", bus.rd_data[DW-1:0], 32'd42);
      idle(5'd0, 5'd0);
      bus.we = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'd43;
      step();
      idle(5'd9, 5'd0);
      step();
      chk("r9_busy_wr", DW'(bus.rd_busy[0]), 32'h0);

      // reset in the middle of an accumulate with concurrent write/reserve
      idle(5'd0, 5'd0);
      bus.hilo_op = 2'd2; bus.hilo_wdata = {32'h0, 32'h5};
      step();
      idle(5'd3, 5'd4);
      rst = 1'b1;
      bus.we = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hCAFE;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      bus.hilo_op = 2'd2; bus.hilo_wdata = {32'h0, 32'h7};
      step();
      chk("rst_mid_hi", bus.hi_out, 32'h0);
      chk("rst_mid_lo", bus.lo_out, 32'h0);
      idle(5'd3, 5'd4);
      step();
      chk("rst_mid_r3", bus.rd_data[DW-1:0], 32'h0);
      chk("rst_mid_r4_busy", DW'(bus.rd_busy[1]), 32'h0);

      // randomized traffic on a narrow address range to force collisions
      for (int c = 0; c < 3000; c++) begin
         logic [AW-1:0] a0, a1;
         a0 = AW'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 7));
         idle(a0, a1);
         rst            = ($urandom_range(0, 99) == 0);
         bus.we         = $urandom_range(0, 1) == 1;
         bus.wr_addr    = AW'($urandom_range(0, 7));
         bus.wr_data    = $urandom;
         bus.rsv_en     = $urandom_range(0, 2) == 0;
         bus.rsv_addr   = ($urandom_range(0, 1) == 1) ? bus.wr_addr : AW'($urandom_range(0, 7));
         bus.hilo_op    = 2'($urandom_range(0, 3));
         bus.hilo_wdata = {$urandom, $urandom};
         step();
      end

      idle(5'd0, 5'd0);
      repeat (2) @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
